// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: FSM state codes, owner
// codes and the port selection rule used in IDLE.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    // A lone requester wins; on a tie the port not served last wins.
    function automatic logic pick_owner(
        input logic if_req,
        input logic dm_req,
        input logic last_owner
    );
        if (if_req && dm_req) begin
            return (last_owner == OWNER_IF) ? OWNER_DM : OWNER_IF;
        end else if (dm_req) begin
            return OWNER_DM;
        end else begin
            return OWNER_IF;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Memory latency down-counter. Loaded when the access is issued and
// decremented while waiting; the zero flag marks the cycle in which the
// memory read data is valid.
module mem_lat_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority over decrement; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the instruction-fetch
// port and the data-memory port. One access is in flight at a time; the
// request fields are latched at grant so later changes on the ports are
// ignored until the next grant.
//
//  state | meaning
//  IDLE  | wait for a request; arbitrate and latch the winner's fields
//  ISSUE | one-cycle mem_en strobe; latency counter loaded with MEM_LAT-1
//  WAIT  | count down; at zero mem_rdata is valid and reads are captured
//  RESP  | owner's valid pulse, last_owner updated, requests ignored
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic w_any_req;
    logic w_grant;
    logic w_idle;
    logic w_issue;
    logic w_wait;
    logic w_resp;
    logic w_cnt_zero;
    logic w_capture;

    assign w_any_req = if_req | dm_req;
    assign w_grant   = pick_owner(if_req, dm_req, r_last_owner);
    assign w_idle    = (r_state == ST_IDLE);
    assign w_issue   = (r_state == ST_ISSUE);
    assign w_wait    = (r_state == ST_WAIT);
    assign w_resp    = (r_state == ST_RESP);
    assign w_capture = w_wait & w_cnt_zero;

    mem_lat_counter #(
        .CNT_W(CNT_W)
    ) u_lat_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_issue),
        .i_load_val(LAT_LOAD),
        .i_dec     (w_wait),
        .o_zero    (w_cnt_zero)
    );

    // Access sequencing: grant, strobe, latency wait, response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_owner <= OWNER_IF;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_last_owner <= r_owner;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Latch the winner's request fields at grant; IF is always a read, and
    // the write-data latch only follows the data port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWNER_IF;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_idle && w_any_req) begin
            r_owner <= w_grant;
            if (w_grant == OWNER_DM) begin
                r_we    <= dm_we;
                r_addr  <= dm_addr;
                r_wdata <= dm_wdata;
            end else begin
                r_we    <= 1'b0;
                r_addr  <= if_addr;
            end
        end
    end

    // Capture read data into the owner's register on the valid cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else if (w_capture && !r_we) begin
            if (r_owner == OWNER_DM) begin
                r_dm_rdata <= mem_rdata;
            end else begin
                r_if_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = w_issue;
    assign mem_we    = w_issue & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_valid  = w_resp & (r_owner == OWNER_IF);
    assign dm_valid  = w_resp & (r_owner == OWNER_DM);
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_stall  = if_req & ~if_valid;
    assign dm_stall  = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle table, reset-in-flight and
// MEM_LAT=1 sequences, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LAT0 = 2;
    localparam int NR   = 2000;

    logic clk;

    // DUT with default latency
    logic        rst, if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, if_stall, dm_valid, dm_stall, mem_en, mem_we;

    // DUT with MEM_LAT=1
    logic        rst1, if_req1, dm_req1, dm_we1;
    logic [31:0] if_addr1, dm_addr1, dm_wdata1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_valid1, if_stall1, dm_valid1, dm_stall1, mem_en1, mem_we1;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT0)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst1),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1),
        .if_valid(if_valid1), .if_stall(if_stall1),
        .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
        .dm_rdata(dm_rdata1), .dm_valid(dm_valid1), .dm_stall(dm_stall1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory models returning ~addr exactly MEM_LAT cycles after mem_en;
    // junk on every other cycle so a mistimed capture shows up.
    logic [31:0] pipe0 [0:LAT0-1];
    logic [31:0] pipe1;
    always @(posedge clk) begin
        pipe0[1] <= pipe0[0];
        pipe0[0] <= mem_en ? ~mem_addr : $urandom;
        pipe1    <= mem_en1 ? ~mem_addr1 : $urandom;
    end
    assign mem_rdata  = pipe0[LAT0-1];
    assign mem_rdata1 = pipe1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, ir;
        logic [31:0] ia;
        logic        dr, dw;
        logic [31:0] da, dd;
        logic        men, mwe;
        logic [31:0] madr, mwd;
        logic        iv;
        logic [31:0] ird;
        logic        dv;
        logic [31:0] drd;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
        input logic men, input logic mwe, input logic [31:0] madr, input logic [31:0] mwd,
        input logic iv, input logic [31:0] ird, input logic dv, input logic [31:0] drd);
        vec_t v;
        v.rst = r;  v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.men = men; v.mwe = mwe; v.madr = madr; v.mwd = mwd;
        v.iv = iv; v.ird = ird; v.dv = dv; v.drd = drd;
        return v;
    endfunction

    localparam logic [31:0] BF  = 32'hFFFF_FFBF;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;
    localparam logic [31:0] D2  = 32'hFFFF_FDFF;
    localparam logic [31:0] C3  = 32'hFFFF_FCFF;
    localparam logic [31:0] D21 = 32'hFFFF_FDEF;
    localparam int NV = 30;

    vec_t tv [NV];

    // random-phase model state
    int          m_issue, m_done, m_next_idle;
    logic        m_owner, m_last, m_we;
    logic [31:0] m_addr, m_wdata, e_if_rd, e_dm_rd;
    logic        e_if_v, e_dm_v, prev_if_v, prev_dm_v, if_act, dm_act;

    initial begin
        // rst ir ia      dr dw da      dd   | men mwe madr    mwd | iv ird dv drd
        tv[0]  = mk(0,0,0,      0,0,0,      0,   0,0,0,      0,  0,0,  0,0);
        tv[1]  = mk(0,1,'h40,   0,0,0,      0,   0,0,0,      0,  0,0,  0,0);
        tv[2]  = mk(0,1,'h40,   0,0,0,      0,   1,0,'h40,   0,  0,0,  0,0);
        tv[3]  = mk(0,1,'h80,   0,0,0,      0,   0,0,'h40,   0,  0,0,  0,0);
        tv[4]  = mk(0,1,'h80,   0,0,0,      0,   0,0,'h40,   0,  0,0,  0,0);
        tv[5]  = mk(0,1,'h80,   0,0,0,      0,   0,0,'h40,   0,  1,BF, 0,0);
        tv[6]  = mk(0,0,0,      0,0,0,      0,   0,0,'h40,   0,  0,BF, 0,0);
        tv[7]  = mk(0,0,0,      1,1,'h100,  DB,  0,0,'h40,   0,  0,BF, 0,0);
        tv[8]  = mk(0,0,0,      1,1,'h100,  DB,  1,1,'h100,  DB, 0,BF, 0,0);
        tv[9]  = mk(0,0,0,      1,1,'h100,  DB,  0,0,'h100,  DB, 0,BF, 0,0);
        tv[10] = mk(0,0,0,      1,1,'h100,  DB,  0,0,'h100,  DB, 0,BF, 0,0);
        tv[11] = mk(0,0,0,      1,1,'h100,  DB,  0,0,'h100,  DB, 0,BF, 1,0);
        tv[12] = mk(1,0,0,      0,0,0,      0,   0,0,'h100,  DB, 0,BF, 0,0);
        tv[13] = mk(0,0,0,      0,0,0,      0,   0,0,0,      0,  0,0,  0,0);
        tv[14] = mk(0,1,'h300,  1,0,'h200,  0,   0,0,0,      0,  0,0,  0,0);
        tv[15] = mk(0,1,'h300,  1,0,'h200,  0,   1,0,'h200,  0,  0,0,  0,0);
        tv[16] = mk(0,1,'h300,  1,0,'h200,  0,   0,0,'h200,  0,  0,0,  0,0);
        tv[17] = mk(0,1,'h300,  1,0,'h200,  0,   0,0,'h200,  0,  0,0,  0,0);
        tv[18] = mk(0,1,'h300,  1,0,'h200,  0,   0,0,'h200,  0,  0,0,  1,D2);
        tv[19] = mk(0,1,'h300,  0,0,0,      0,   0,0,'h200,  0,  0,0,  0,D2);
        tv[20] = mk(0,1,'h300,  0,0,0,      0,   1,0,'h300,  0,  0,0,  0,D2);
        tv[21] = mk(0,1,'h300,  0,0,0,      0,   0,0,'h300,  0,  0,0,  0,D2);
        tv[22] = mk(0,1,'h300,  0,0,0,      0,   0,0,'h300,  0,  0,0,  0,D2);
        tv[23] = mk(0,1,'h300,  0,0,0,      0,   0,0,'h300,  0,  1,C3, 0,D2);
        tv[24] = mk(0,1,'h310,  1,0,'h210,  0,   0,0,'h300,  0,  0,C3, 0,D2);
        tv[25] = mk(0,1,'h310,  1,0,'h210,  0,   1,0,'h210,  0,  0,C3, 0,D2);
        tv[26] = mk(0,1,'h310,  1,0,'h210,  0,   0,0,'h210,  0,  0,C3, 0,D2);
        tv[27] = mk(0,1,'h310,  1,0,'h210,  0,   0,0,'h210,  0,  0,C3, 0,D2);
        tv[28] = mk(0,1,'h310,  1,0,'h210,  0,   0,0,'h210,  0,  0,C3, 1,D21);
        tv[29] = mk(0,0,0,      0,0,0,      0,   0,0,'h210,  0,  0,C3, 0,D21);

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        rst1 = 1'b1; if_req1 = 1'b0; if_addr1 = '0;
        dm_req1 = 1'b0; dm_we1 = 1'b0; dm_addr1 = '0; dm_wdata1 = '0;
        repeat (2) @(posedge clk);

        // ---- directed cycle table ----
        for (int k = 0; k < NV; k++) begin
            @(posedge clk); #1;
            rst = tv[k].rst; if_req = tv[k].ir; if_addr = tv[k].ia;
            dm_req = tv[k].dr; dm_we = tv[k].dw; dm_addr = tv[k].da; dm_wdata = tv[k].dd;
            @(negedge clk);
            chk($sformatf("row%0d mem_en", k),    32'(mem_en),    32'(tv[k].men));
            chk($sformatf("row%0d mem_we", k),    32'(mem_we),    32'(tv[k].mwe));
            chk($sformatf("row%0d mem_addr", k),  mem_addr,       tv[k].madr);
            chk($sformatf("row%0d mem_wdata", k), mem_wdata,      tv[k].mwd);
            chk($sformatf("row%0d if_valid", k),  32'(if_valid),  32'(tv[k].iv));
            chk($sformatf("row%0d if_rdata", k),  if_rdata,       tv[k].ird);
            chk($sformatf("row%0d dm_valid", k),  32'(dm_valid),  32'(tv[k].dv));
            chk($sformatf("row%0d dm_rdata", k),  dm_rdata,       tv[k].drd);
            chk($sformatf("row%0d if_stall", k),  32'(if_stall),  32'(tv[k].ir & ~tv[k].iv));
            chk($sformatf("row%0d dm_stall", k),  32'(dm_stall),  32'(tv[k].dr & ~tv[k].dv));
        end

        // ---- reset in the middle of a fetch ----
        @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h40;           // T
        @(negedge clk); chk("rmid T stall", 32'(if_stall), 32'd1);
        @(posedge clk); #1;                                             // T+1
        @(negedge clk); chk("rmid T+1 mem_en", 32'(mem_en), 32'd1);
        chk("rmid T+1 mem_addr", mem_addr, 32'h40);
        @(posedge clk); #1; rst = 1'b1;                                 // T+2
        @(negedge clk); chk("rmid T+2 if_valid", 32'(if_valid), 32'd0);
        @(posedge clk); #1; rst = 1'b0;                                 // T+3
        @(negedge clk);
        chk("rmid T+3 mem_en", 32'(mem_en), 32'd0);
        chk("rmid T+3 mem_addr", mem_addr, 32'd0);
        chk("rmid T+3 mem_wdata", mem_wdata, 32'd0);
        chk("rmid T+3 if_rdata", if_rdata, 32'd0);
        chk("rmid T+3 dm_rdata", dm_rdata, 32'd0);
        chk("rmid T+3 if_valid", 32'(if_valid), 32'd0);
        chk("rmid T+3 if_stall", 32'(if_stall), 32'd1);
        @(posedge clk); #1;                                             // T+4
        @(negedge clk);
        chk("rmid T+4 mem_en", 32'(mem_en), 32'd1);
        chk("rmid T+4 mem_addr", mem_addr, 32'h40);
        chk("rmid T+4 if_valid", 32'(if_valid), 32'd0);
        for (int k = 5; k <= 6; k++) begin
            @(posedge clk); #1;
            @(negedge clk); chk($sformatf("rmid T+%0d if_valid", k), 32'(if_valid), 32'd0);
        end
        @(posedge clk); #1;                                             // T+7
        @(negedge clk);
        chk("rmid T+7 if_valid", 32'(if_valid), 32'd1);
        chk("rmid T+7 if_rdata", if_rdata, BF);
        @(posedge clk); #1; if_req = 1'b0;

        // ---- MEM_LAT=1 single load ----
        rst1 = 1'b0; dm_req1 = 1'b1; dm_we1 = 1'b0; dm_addr1 = 32'h55;  // T
        @(negedge clk);
        chk("lat1 T mem_en", 32'(mem_en1), 32'd0);
        chk("lat1 T dm_stall", 32'(dm_stall1), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat1 T+1 mem_en", 32'(mem_en1), 32'd1);
        chk("lat1 T+1 mem_addr", mem_addr1, 32'h55);
        @(posedge clk); #1;
        @(negedge clk); chk("lat1 T+2 dm_valid", 32'(dm_valid1), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat1 T+3 dm_valid", 32'(dm_valid1), 32'd1);
        chk("lat1 T+3 dm_rdata", dm_rdata1, 32'hFFFF_FFAA);
        chk("lat1 T+3 if_valid", 32'(if_valid1), 32'd0);
        @(posedge clk); #1; dm_req1 = 1'b0;

        // ---- random traffic against a transaction-level model ----
        rst = 1'b1;
        repeat (2) @(posedge clk);
        m_issue = -1; m_done = -1; m_next_idle = 0;
        m_owner = 1'b0; m_last = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        e_if_rd = '0; e_dm_rd = '0; prev_if_v = 1'b0; prev_dm_v = 1'b0;
        if_act = 1'b0; dm_act = 1'b0;
        for (int c = 0; c < NR; c++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            if (if_act && prev_if_v) if_act = 1'b0;
            if (dm_act && prev_dm_v) dm_act = 1'b0;
            if (!if_act && $urandom_range(0, 2) == 0) begin
                if_act = 1'b1; if_addr = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                if_addr = $urandom;
            end
            if (!dm_act && $urandom_range(0, 2) == 0) begin
                dm_act = 1'b1; dm_addr = $urandom; dm_wdata = $urandom;
                dm_we = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 3) == 0) begin
                dm_addr = $urandom; dm_wdata = $urandom;
                dm_we = 1'($urandom_range(0, 1));
            end
            if_req = if_act;
            dm_req = dm_act;
            @(negedge clk);
            e_if_v = (c == m_done) && !m_owner;
            e_dm_v = (c == m_done) && m_owner;
            if ((c == m_done) && !m_we) begin
                if (m_owner) e_dm_rd = ~m_addr;
                else         e_if_rd = ~m_addr;
            end
            chk("rnd if_valid", 32'(if_valid), 32'(e_if_v));
            chk("rnd dm_valid", 32'(dm_valid), 32'(e_dm_v));
            chk("rnd if_rdata", if_rdata, e_if_rd);
            chk("rnd dm_rdata", dm_rdata, e_dm_rd);
            chk("rnd if_stall", 32'(if_stall), 32'(if_req & ~e_if_v));
            chk("rnd dm_stall", 32'(dm_stall), 32'(dm_req & ~e_dm_v));
            chk("rnd mem_en", 32'(mem_en), 32'(c == m_issue));
            chk("rnd mem_we", 32'(mem_we), 32'((c == m_issue) && m_we));
            if (c == m_issue) begin
                chk("rnd mem_addr", mem_addr, m_addr);
                if (m_we) chk("rnd mem_wdata", mem_wdata, m_wdata);
            end
            if (c >= m_next_idle && (if_req || dm_req)) begin
                if (if_req && dm_req) m_owner = ~m_last;
                else                  m_owner = dm_req;
                m_last      = m_owner;
                m_addr      = m_owner ? dm_addr : if_addr;
                m_we        = m_owner & dm_we;
                m_wdata     = dm_wdata;
                m_issue     = c + 1;
                m_done      = c + LAT0 + 2;
                m_next_idle = c + LAT0 + 3;
            end
            prev_if_v = e_if_v;
            prev_dm_v = e_dm_v;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared single-port memory between the pipeline's instruction-fetch port and data-memory port. Requests on the data port come from the controller's `readmem`/`writemem` decode.

- The block sequences each access through a fixed-latency memory.
- It returns read data or a write acknowledge to the owning port.
- It drives per-port stall signals that freeze the pipeline while an access is outstanding.
- It sits between the IF and MEM stages and the unified memory model.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 2: cycles from `mem_en` to valid `mem_rdata`. Must be ≥1.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request. Held until `if_valid`.
- `if_addr` in ADDR_W: fetch address.
- `if_rdata` out DATA_W: fetched word (registered).
- `if_valid` out 1: one-cycle completion pulse for fetch.
- `if_stall` out 1: `if_req & ~if_valid` (combinational).
- `dm_req` in 1: data request, equal to `readmem | writemem`. Held until `dm_valid`.
- `dm_we` in 1: 1 = write, 0 = read.
- `dm_addr` in ADDR_W: data address.
- `dm_wdata` in DATA_W: store data.
- `dm_rdata` out DATA_W: load data (registered).
- `dm_valid` out 1: one-cycle completion pulse for data (read or write).
- `dm_stall` out 1: `dm_req & ~dm_valid` (combinational).
- `mem_en` out 1: memory access strobe, one cycle per access.
- `mem_we` out 1: memory write enable, valid only with `mem_en`.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid exactly MEM_LAT cycles after `mem_en`.

## Operation
States: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any request is present, latch owner, addr, we and wdata, then go to ISSUE.
  - Arbitration when only one port requests: that port wins.
  - Arbitration when both request: the port not served last wins. The `last_owner` register resets to IF, so DM wins the first tie.
- **ISSUE:**
  - Drive `mem_en`=1 and `mem_we`, `mem_addr`, `mem_wdata` from the latches.
  - Load the latency counter with MEM_LAT−1 and go to WAIT.
- **WAIT:**
  - Decrement the counter.
  - When the counter is 0, this cycle `mem_rdata` is valid. Capture it into the owner's rdata register (reads only) and go to RESP.
  - Counter width is `$clog2(MEM_LAT+1)`.
  - MEM_LAT=1 passes through WAIT for exactly one cycle.
- **RESP:**
  - Assert the owner's `*_valid`=1 and update `last_owner`.
  - Requests are ignored this cycle; the requester drops or changes `req` on the following edge.
  - Next state is IDLE.
- Writes: `dm_valid` pulses in RESP and `dm_rdata` is unchanged. A write on the IF port is impossible; `if` is always a read.
- Non-owner port: its rdata register holds its previous value and its valid stays 0. Its stall stays high while its req is high.
- Request fields changing while the access is in flight have no effect, because the latched copy is used.
- Outside ISSUE, `mem_en` and `mem_we` are 0. `mem_addr` and `mem_wdata` hold the latched values.

## Timing
- Request sampled in IDLE at cycle T:
  - `mem_en` at T+1.
  - `mem_rdata` captured at T+1+MEM_LAT.
  - `*_valid` and `*_rdata` visible at T+2+MEM_LAT.
  - Total MEM_LAT+2 cycles (4 at the default).
- Back-to-back: the next request is sampled at the earliest in the cycle after RESP. Throughput is one access per MEM_LAT+3 cycles.
- Reset values:
  - State IDLE, counter 0, `last_owner`=IF.
  - `mem_en`=`mem_we`=0; `mem_addr`=`mem_wdata`=0.
  - `if_rdata`=`dm_rdata`=0; `if_valid`=`dm_valid`=0.
- Reset mid-operation: the in-flight access is abandoned and no valid pulse is issued. Late `mem_rdata` is ignored. Requests are sampled normally from the first post-reset IDLE cycle.

## Structure
- State encodings (2-bit) and the owner encoding (IF=0, DM=1) go in the shared `arbiter_constants.vh`, included like `controller_constants.vh`.
- One sub-module, `mem_lat_counter`:
  - Inputs: load, load value, decrement enable.
  - Output: zero flag.
  - Parameterised by width.
- The FSM and datapath latches stay in `mem_port_arbiter`.

## Test plan
All scenarios use MEM_LAT=2, with the memory model returning `~addr`.
- **Single fetch:** `if_req`=1, `if_addr`=0x40 at T → `mem_en`=1 with addr 0x40 at T+1. `if_valid`=1 and `if_rdata`=0xFFFFFFBF at T+4. `if_stall` is high T..T+3 and low at T+4.
- **Store:** `dm_req`=1, `dm_we`=1, `dm_addr`=0x100, `dm_wdata`=0xDEADBEEF → at T+1 `mem_en`=`mem_we`=1 with that addr and data. `dm_valid` at T+4, `dm_rdata` unchanged, `if_valid` stays 0.
- **Simultaneous requests:** from reset, `if_req` and `dm_req` (load 0x200) both asserted at T:
  - DM is served first, with `dm_valid` at T+4.
  - IF is sampled at T+5, with `if_valid` at T+9.
  - With both re-asserted again, the next grant alternates to DM.
- **Field change in flight:** change `if_addr` to 0x80 at T+2 → `mem_addr` stays 0x40 and `if_rdata`=0xFFFFFFBF.
- **Reset mid-op:** `rst` pulsed at T+2 of a fetch → no `if_valid`, outputs at reset values at T+3. A still-high `if_req` is re-sampled at T+3, with `mem_en` at T+4.
- **MEM_LAT=1 build:** single load completes with `dm_valid` at T+3.
